// File: rtl/sni_uart.sv
// 8N1 serial transceiver between the board UART pins and the sni command engine.
// Independent RX and TX FSMs share one bit-period divider setting; RTS mirrors rbf, CTS gates TX.
module sni_uart #(
  parameter int unsigned CLK_DIV = 186,
  parameter bit          USE_CTS = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        uart_rxd,
  output logic        uart_txd,
  output logic        uart_rts_n,
  input  logic        uart_cts_n,
  input  logic        rbf,
  output logic        rxint,
  output logic [15:0] rdata_m,
  input  logic        tdata_i,
  input  logic [15:0] tdata_m,
  output logic        txint
);

  localparam int unsigned   CntW     = $clog2(CLK_DIV);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLK_DIV - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(CLK_DIV / 2 - 1);
  localparam logic [7:0]    OpSend   = 8'h01;

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;
  typedef enum logic [2:0] {TxIdle, TxNop, TxWait, TxStart, TxData, TxStop} tx_state_e;

  rx_state_e r_rx_state, w_rx_state;
  tx_state_e r_tx_state, w_tx_state;

  logic            r_rxd_s1, r_rxd_s2, r_rxd_d, r_cts_s1, r_cts_s2;
  logic [CntW-1:0] r_rx_cnt, r_tx_cnt;
  logic [2:0]      r_rx_idx, r_tx_idx;
  logic [7:0]      r_rx_shift, r_rx_byte, r_tx_byte;
  logic            r_ovr, r_ferr, r_acc_d, r_rxint, r_rts_n, r_txd, r_txint;
  logic            w_rx_fall, w_rx_hit, w_rx_sample, w_rx_accept, w_rx_ovr, w_rx_ferr;
  logic            w_tx_hit, w_cts_ok;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rxd_s1 <= 1'b1;
      r_rxd_s2 <= 1'b1;
      r_rxd_d  <= 1'b1;
      r_cts_s1 <= 1'b1;
      r_cts_s2 <= 1'b1;
    end else begin
      r_rxd_s1 <= uart_rxd;
      r_rxd_s2 <= r_rxd_s1;
      r_rxd_d  <= r_rxd_s2;
      r_cts_s1 <= uart_cts_n;
      r_cts_s2 <= r_cts_s1;
    end
  end

  // ---------------------------------------------------------------- RX
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_rx_state <= RxIdle;
    else          r_rx_state <= w_rx_state;
  end

  assign w_rx_fall = r_rxd_d & ~r_rxd_s2;
  // Start bit is checked half a period in; every later sample lands mid-bit.
  assign w_rx_hit  = (r_rx_state == RxStart) ? (r_rx_cnt == HalfLast) : (r_rx_cnt == BitLast);

  always_comb begin
    w_rx_state = r_rx_state;
    case (r_rx_state)
      RxIdle:  if (w_rx_fall) w_rx_state = RxStart;
      RxStart: if (w_rx_hit) w_rx_state = r_rxd_s2 ? RxIdle : RxData;
      RxData:  if (w_rx_hit && r_rx_idx == 3'd7) w_rx_state = RxStop;
      RxStop:  if (w_rx_hit) w_rx_state = RxIdle;
      default: w_rx_state = RxIdle;
    endcase
  end

  always_comb begin
    w_rx_sample = w_rx_hit && (r_rx_state == RxData);
    w_rx_accept = w_rx_hit && (r_rx_state == RxStop) && r_rxd_s2 && !rbf;
    w_rx_ovr    = w_rx_hit && (r_rx_state == RxStop) && r_rxd_s2 && rbf;
    w_rx_ferr   = w_rx_hit && (r_rx_state == RxStop) && !r_rxd_s2;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_rx_cnt   <= '0;
      r_rx_idx   <= '0;
      r_rx_shift <= '0;
      r_rx_byte  <= '0;
      r_ovr      <= 1'b0;
      r_ferr     <= 1'b0;
      r_acc_d    <= 1'b0;
      r_rxint    <= 1'b0;
      r_rts_n    <= 1'b1;
    end else begin
      r_rx_cnt <= (r_rx_state == RxIdle || w_rx_hit) ? '0 : r_rx_cnt + CntW'(1);
      if (r_rx_state == RxStart) r_rx_idx <= '0;
      else if (w_rx_sample)      r_rx_idx <= r_rx_idx + 3'd1;
      if (w_rx_sample) r_rx_shift <= {r_rxd_s2, r_rx_shift[7:1]};
      if (w_rx_accept) r_rx_byte <= r_rx_shift;
      if (w_rx_ovr)    r_ovr <= 1'b1;
      if (w_rx_ferr)   r_ferr <= 1'b1;
      // Two-cycle rxint: the accept strobe plus its one-cycle echo.
      r_acc_d <= w_rx_accept;
      r_rxint <= w_rx_accept | r_acc_d;
      r_rts_n <= rbf;
    end
  end

  // ---------------------------------------------------------------- TX
  assign w_tx_hit = (r_tx_cnt == BitLast);
  assign w_cts_ok = !USE_CTS || !r_cts_s2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_tx_state <= TxIdle;
    else          r_tx_state <= w_tx_state;
  end

  always_comb begin
    w_tx_state = r_tx_state;
    case (r_tx_state)
      TxIdle:  if (tdata_i) w_tx_state = (tdata_m[15:8] == OpSend) ? TxWait : TxNop;
      TxNop:   if (r_tx_cnt[0]) w_tx_state = TxIdle;
      TxWait:  if (w_cts_ok) w_tx_state = TxStart;
      TxStart: if (w_tx_hit) w_tx_state = TxData;
      TxData:  if (w_tx_hit && r_tx_idx == 3'd7) w_tx_state = TxStop;
      TxStop:  if (w_tx_hit) w_tx_state = TxIdle;
      default: w_tx_state = TxIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_tx_cnt  <= '0;
      r_tx_idx  <= '0;
      r_tx_byte <= '0;
      r_txd     <= 1'b1;
      r_txint   <= 1'b0;
    end else begin
      r_tx_cnt <= (r_tx_state == TxIdle || r_tx_state == TxWait || w_tx_hit) ? '0
                                                                              : r_tx_cnt + CntW'(1);
      case (r_tx_state)
        TxIdle: if (tdata_i) begin
          r_tx_byte <= tdata_m[7:0];
          r_txint   <= 1'b1;
        end
        TxNop:  if (r_tx_cnt[0]) r_txint <= 1'b0;
        TxWait: if (w_cts_ok) r_txd <= 1'b0;
        TxStart: if (w_tx_hit) begin
          r_txd     <= r_tx_byte[0];
          r_tx_byte <= r_tx_byte >> 1;
          r_tx_idx  <= '0;
        end
        TxData: if (w_tx_hit) begin
          if (r_tx_idx == 3'd7) begin
            r_txd <= 1'b1;
          end else begin
            r_txd     <= r_tx_byte[0];
            r_tx_byte <= r_tx_byte >> 1;
          end
          r_tx_idx <= r_tx_idx + 3'd1;
        end
        TxStop: if (w_tx_hit) r_txint <= 1'b0;
        default: ;
      endcase
    end
  end

  assign uart_txd   = r_txd;
  assign uart_rts_n = r_rts_n;
  assign rxint      = r_rxint;
  assign txint      = r_txint;
  assign rdata_m    = {6'b0, r_ferr, r_ovr, r_rx_byte};

endmodule

// File: tb/tb_sni_uart.sv
// Directed bench for sni_uart at CLK_DIV=16, USE_CTS=1; expected values are hand-derived cycle counts.
module tb_sni_uart;
  localparam int ClkDiv = 16;

  logic        clk, reset_n, uart_rxd, uart_txd, uart_rts_n, uart_cts_n, rbf;
  logic        rxint, tdata_i, txint;
  logic [15:0] rdata_m, tdata_m;
  int          n_checks, n_pass;

  sni_uart #(.CLK_DIV(ClkDiv), .USE_CTS(1'b1)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .uart_rxd   (uart_rxd),
    .uart_txd   (uart_txd),
    .uart_rts_n (uart_rts_n),
    .uart_cts_n (uart_cts_n),
    .rbf        (rbf),
    .rxint      (rxint),
    .rdata_m    (rdata_m),
    .tdata_i    (tdata_i),
    .tdata_m    (tdata_m),
    .txint      (txint)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one frame; k counts cycles from the start-bit drive, reports rxint activity.
  task automatic rx_frame(input logic [7:0] data, input logic stop_bit,
                          output int first_hi, output int n_hi);
    first_hi = -1;
    n_hi     = 0;
    for (int k = 0; k < 11 * ClkDiv; k++) begin
      int bi;
      step();
      bi = k / ClkDiv;
      if (bi == 0)      uart_rxd = 1'b0;
      else if (bi <= 8) uart_rxd = data[bi-1];
      else if (bi == 9) uart_rxd = stop_bit;
      else              uart_rxd = 1'b1;
      if (rxint) begin
        if (first_hi < 0) first_hi = k;
        n_hi++;
      end
    end
  endtask

  task automatic tx_request(input logic [15:0] cmd);
    step();
    tdata_m = cmd;
    tdata_i = 1'b1;
    step();
    tdata_i = 1'b0;
  endtask

  initial begin
    int          first_hi, n_hi, fall_k, cnt, lows, lat;
    logic [9:0]  exp_frame;
    n_checks   = 0;
    n_pass     = 0;
    reset_n    = 1'b0;
    uart_rxd   = 1'b1;
    uart_cts_n = 1'b0;
    rbf        = 1'b0;
    tdata_i    = 1'b0;
    tdata_m    = 16'h0;
    repeat (3) step();
    check("rst_txd", uart_txd, 1);
    check("rst_rts_n", uart_rts_n, 1);
    check("rst_rxint", rxint, 0);
    check("rst_txint", txint, 0);
    check("rst_rdata", rdata_m, 16'h0000);
    reset_n = 1'b1;
    repeat (3) step();
    check("rts_low_idle", uart_rts_n, 0);

    // 1: valid frame 0xA5
    rx_frame(8'hA5, 1'b1, first_hi, n_hi);
    check("rx_a5_data", rdata_m, 16'h00A5);
    check("rx_a5_rxint_len", n_hi, 2);
    check("rx_a5_rxint_lat", first_hi, 155);

    // 3: 4-cycle glitch then valid 0x3C
    cnt = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      uart_rxd = (k < 4) ? 1'b0 : 1'b1;
      if (rxint) cnt++;
    end
    check("glitch_no_rxint", cnt, 0);
    check("glitch_rdata", rdata_m, 16'h00A5);
    rx_frame(8'h3C, 1'b1, first_hi, n_hi);
    check("rx_3c_data", rdata_m, 16'h003C);
    check("rx_3c_rxint_len", n_hi, 2);

    // 4: framing error
    rx_frame(8'h7E, 1'b0, first_hi, n_hi);
    check("ferr_no_rxint", n_hi, 0);
    check("ferr_rdata", rdata_m, 16'h023C);

    // 5: receive buffer full
    step();
    rbf = 1'b1;
    step();
    step();
    check("rbf_rts_n", uart_rts_n, 1);
    rx_frame(8'h11, 1'b1, first_hi, n_hi);
    check("ovr_no_rxint", n_hi, 0);
    check("ovr_rdata", rdata_m, 16'h033C);
    rbf = 1'b0;
    step();
    step();
    check("rbf_clear_rts_n", uart_rts_n, 0);

    // 2: transmit 0x55
    tx_request(16'h0155);
    check("tx_txint_next", txint, 1);
    exp_frame = {1'b1, 8'h55, 1'b0};
    fall_k = -1;
    for (int k = 2; k <= 170; k++) begin
      step();
      if (k >= 10 && k <= 154 && (k - 10) % ClkDiv == 0)
        check($sformatf("tx_bit%0d", (k - 10) / ClkDiv), uart_txd, exp_frame[(k - 10) / ClkDiv]);
      if (!txint && fall_k < 0) fall_k = k;
    end
    check("tx_txint_fall", fall_k, 162);

    // Non-send opcode: 2-cycle txint, line stays idle
    tx_request(16'h0200);
    cnt  = txint ? 1 : 0;
    lows = 0;
    for (int k = 0; k < 8; k++) begin
      step();
      if (txint) cnt++;
      if (!uart_txd) lows++;
    end
    check("nop_txint_len", cnt, 2);
    check("nop_txd_idle", lows, 0);

    // 6: reset during data bit 4 of 0xAA
    tx_request(16'h01AA);
    for (int k = 2; k <= 90; k++) step();
    check("tx_bit4_pre", uart_txd, 0);
    uart_cts_n = 1'b1;
    #3;
    reset_n = 1'b0;
    #1;
    check("rst_mid_txd", uart_txd, 1);
    check("rst_mid_txint", txint, 0);
    repeat (3) step();
    check("rst_mid_rts_n", uart_rts_n, 1);
    check("rst_mid_rdata", rdata_m, 16'h0000);
    reset_n = 1'b1;
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (txint || rxint) cnt++;
    end
    check("rst_release_quiet", cnt, 0);
    tx_request(16'h0142);
    cnt  = 0;
    lows = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (!txint) cnt++;
      if (!uart_txd) lows++;
    end
    check("cts_hold_txint", cnt, 0);
    check("cts_hold_txd", lows, 0);
    uart_cts_n = 1'b0;
    lat = -1;
    for (int k = 1; k <= 8; k++) begin
      step();
      if (!uart_txd) begin
        lat = k;
        break;
      end
    end
    check("cts_start_lat", lat, 3);
    fall_k = -1;
    for (int k = 1; k <= 200; k++) begin
      step();
      if (!txint && fall_k < 0) fall_k = k;
    end
    check("cts_txint_fall", fall_k, 160);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
